// File: rtl/lcd_timing_gen_if.sv
// rtl/lcd_timing_gen_if.sv - pixel-stream timing bundle between the LCD timing source and scan stages
// master: timing generator (drives sync/de/coords/pattern, receives i_en)
// slave : consumer (drives i_en, receives everything else)
interface lcd_timing_gen_if;
    logic        i_en;
    logic        o_hs;
    logic        o_vs;
    logic        o_de;
    logic [11:0] o_x;
    logic [11:0] o_y;
    logic        o_fs;
    logic        o_th;
    logic [15:0] o_data;

    modport master (
        input  i_en,
        output o_hs, o_vs, o_de, o_x, o_y, o_fs, o_th, o_data
    );

    modport slave (
        output i_en,
        input  o_hs, o_vs, o_de, o_x, o_y, o_fs, o_th, o_data
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - hs/vs/de, active x/y, frame-start and threshold stream for a 480x272 LCD
// Ports: clk (pixel clock), rst_n (async active-low reset),
//        bus (lcd_timing_gen_if.master): i_en in; o_hs, o_vs, o_de, o_x, o_y, o_fs, o_th, o_data out.
// Optional macro TEST_PATTERN_EN: 16x16 checkerboard on o_th / o_data; otherwise both tied to 0.
module lcd_timing_gen #(
    parameter int   H_ACTIVE = 480,
    parameter int   H_FP     = 2,
    parameter int   H_SYNC   = 41,
    parameter int   H_BP     = 2,
    parameter int   V_ACTIVE = 272,
    parameter int   V_FP     = 2,
    parameter int   V_SYNC   = 10,
    parameter int   V_BP     = 2,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_timing_gen_if.master   bus
);
    localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    // en_q marks that the counters hold a live position. Counting only starts
    // once en_q is high so the (0,0) position is always presented first, and
    // outputs stay live one cycle after i_en drops (counters clear first,
    // outputs follow a cycle later).
    logic        en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            en_q <= bus.i_en;
            if (!bus.i_en) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (en_q) begin
                if (h_cnt == 12'(H_TOTAL - 1)) begin
                    h_cnt <= '0;
                    if (v_cnt == 12'(V_TOTAL - 1)) begin
                        v_cnt <= '0;
                    end else begin
                        v_cnt <= v_cnt + 12'd1;
                    end
                end else begin
                    h_cnt <= h_cnt + 12'd1;
                end
            end
        end
    end

    logic        h_sync_d;
    logic        v_sync_d;
    logic        de_d;
    logic [11:0] x_d;
    logic [11:0] y_d;
    logic        fs_d;

    always_comb begin
        h_sync_d = (h_cnt < 12'(H_SYNC));
        v_sync_d = (v_cnt < 12'(V_SYNC));
        de_d     = (h_cnt >= 12'(H_ACT_START)) && (h_cnt < 12'(H_ACT_END)) &&
                   (v_cnt >= 12'(V_ACT_START)) && (v_cnt < 12'(V_ACT_END));
        x_d      = de_d ? (h_cnt - 12'(H_ACT_START)) : 12'd0;
        y_d      = de_d ? (v_cnt - 12'(V_ACT_START)) : 12'd0;
        fs_d     = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_hs <= ~HS_POL;
            bus.o_vs <= ~VS_POL;
            bus.o_de <= 1'b0;
            bus.o_x  <= '0;
            bus.o_y  <= '0;
            bus.o_fs <= 1'b0;
        end else if (!en_q) begin
            bus.o_hs <= ~HS_POL;
            bus.o_vs <= ~VS_POL;
            bus.o_de <= 1'b0;
            bus.o_x  <= '0;
            bus.o_y  <= '0;
            bus.o_fs <= 1'b0;
        end else begin
            bus.o_hs <= h_sync_d ? HS_POL : ~HS_POL;
            bus.o_vs <= v_sync_d ? VS_POL : ~VS_POL;
            bus.o_de <= de_d;
            bus.o_x  <= x_d;
            bus.o_y  <= y_d;
            bus.o_fs <= fs_d;
        end
    end

`ifdef TEST_PATTERN_EN
    // Checkerboard bit is computed from the same pre-register coordinates so it
    // lands in the same cycle as o_de/o_x/o_y.
    logic th_d;

    always_comb begin
        th_d = de_d & (x_d[4] ^ y_d[4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_th   <= 1'b0;
            bus.o_data <= '0;
        end else if (!en_q) begin
            bus.o_th   <= 1'b0;
            bus.o_data <= '0;
        end else begin
            bus.o_th   <= th_d;
            bus.o_data <= {16{th_d}};
        end
    end
`else
    assign bus.o_th   = 1'b0;
    assign bus.o_data = 16'h0000;
`endif
endmodule
